// File: rtl/mem_access_stage_pkg.sv
// Shared types and control-bit positions for the MEM pipeline stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_e;

  // Bit positions inside mem_control_in / wb_control_in
  localparam int MEMCTL_BRANCH    = 2;
  localparam int MEMCTL_READ      = 1;
  localparam int MEMCTL_WRITE     = 0;
  localparam int WBCTL_REG_WRITE  = 1;
  localparam int WBCTL_MEM_TO_REG = 0;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response channel between the MEM stage (master) and memory (slave).
interface mem_access_stage_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_we;
  logic [DATA_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0] mem_req_wdata;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/mem_access_stage_req_fsm.sv
// Memory-access sequencer: tracks IDLE/REQ/WAIT, drives the request handshake,
// the upstream stall and a one-cycle retire strobe for the MEM/WB registers.
module mem_req_fsm
  import mem_stage_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_valid,
  input  logic i_mem_read,
  input  logic i_mem_write,
  input  logic i_misalign,
  input  logic i_req_ready,
  input  logic i_resp_valid,
  output logic o_stall,
  output logic o_req_valid,
  output logic o_req_we,
  output logic o_retire,
  output logic o_load_done
);
  mem_state_e r_state;
  mem_state_e w_next_state;
  logic       w_memop;
  logic       w_store;

  assign w_memop = i_valid & (i_mem_read | i_mem_write);
  // A set read bit wins, so both bits set is treated as a load
  assign w_store = i_mem_write & ~i_mem_read;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, handshake and stall decode
  always_comb begin
    w_next_state = r_state;
    o_stall      = 1'b0;
    o_req_valid  = 1'b0;
    o_req_we     = 1'b0;
    o_retire     = 1'b0;
    o_load_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_memop && !i_misalign) begin
          o_stall      = 1'b1;
          w_next_state = REQ;
        end else begin
          o_retire = i_valid;
        end
      end
      REQ: begin
        o_req_valid = 1'b1;
        o_req_we    = w_store;
        if (i_req_ready) begin
          if (w_store) begin
            o_retire     = 1'b1;
            w_next_state = IDLE;
          end else begin
            o_stall      = 1'b1;
            w_next_state = WAIT;
          end
        end else begin
          o_stall = 1'b1;
        end
      end
      WAIT: begin
        if (i_resp_valid) begin
          o_retire     = 1'b1;
          o_load_done  = 1'b1;
          w_next_state = IDLE;
        end else begin
          o_stall = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end
endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: branch resolution, data-memory access and MEM/WB payload registers.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int REG_ID_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic [DATA_WIDTH-1:0]   target_in,
  input  logic                    branch_decision_in,
  input  logic [DATA_WIDTH-1:0]   alu_res_in,
  input  logic [DATA_WIDTH-1:0]   write_data_in,
  input  logic [REG_ID_WIDTH-1:0] dest_in,
  input  logic [2:0]              mem_control_in,
  input  logic [1:0]              wb_control_in,
  output logic                    stall_out,
  output logic                    pc_src_out,
  output logic [DATA_WIDTH-1:0]   target_out,
  mem_access_stage_if.master      mem,
  output logic                    valid_out,
  output logic [DATA_WIDTH-1:0]   read_data_out,
  output logic [DATA_WIDTH-1:0]   alu_res_out,
  output logic [REG_ID_WIDTH-1:0] dest_out,
  output logic [1:0]              wb_control_out,
  output logic                    misalign_out
);
  logic                    w_retire;
  logic                    w_load_done;
  logic                    w_misalign;
  logic [1:0]              w_wb_retire;
  logic                    r_valid;
  logic [DATA_WIDTH-1:0]   r_read_data;
  logic [DATA_WIDTH-1:0]   r_alu_res;
  logic [REG_ID_WIDTH-1:0] r_dest;
  logic [1:0]              r_wb;

  assign pc_src_out         = valid_in & mem_control_in[MEMCTL_BRANCH] & branch_decision_in;
  assign target_out         = target_in;
  assign mem.mem_req_addr   = alu_res_in;
  assign mem.mem_req_wdata  = write_data_in;

  mem_req_fsm u_fsm (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (valid_in),
    .i_mem_read   (mem_control_in[MEMCTL_READ]),
    .i_mem_write  (mem_control_in[MEMCTL_WRITE]),
    .i_misalign   (w_misalign),
    .i_req_ready  (mem.mem_req_ready),
    .i_resp_valid (mem.mem_resp_valid),
    .o_stall      (stall_out),
    .o_req_valid  (mem.mem_req_valid),
    .o_req_we     (mem.mem_req_we),
    .o_retire     (w_retire),
    .o_load_done  (w_load_done)
  );

`ifdef MEM_MISALIGN_CHECK_EN
  logic r_misalign;

  assign w_misalign = valid_in
                    & (mem_control_in[MEMCTL_READ] | mem_control_in[MEMCTL_WRITE])
                    & (alu_res_in[2:0] != 3'd0);

  // Misalign flag travels with the retiring instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misalign <= 1'b0;
    end else if (w_retire) begin
      r_misalign <= w_misalign;
    end
  end

  assign misalign_out = r_misalign;
`else
  assign w_misalign   = 1'b0;
  assign misalign_out = 1'b0;
`endif

  // A trapped access must not write the register file
  always_comb begin
    w_wb_retire = wb_control_in;
    if (w_misalign) begin
      w_wb_retire[WBCTL_REG_WRITE] = 1'b0;
    end else begin
      w_wb_retire[WBCTL_MEM_TO_REG] = wb_control_in[WBCTL_MEM_TO_REG];
    end
  end

  // MEM/WB payload: load on retire, bubble otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_read_data <= {DATA_WIDTH{1'b0}};
      r_alu_res   <= {DATA_WIDTH{1'b0}};
      r_dest      <= {REG_ID_WIDTH{1'b0}};
      r_wb        <= 2'b00;
    end else begin
      r_valid <= w_retire;
      if (w_retire) begin
        r_alu_res <= alu_res_in;
        r_dest    <= dest_in;
        r_wb      <= w_wb_retire;
      end else begin
        r_wb <= 2'b00;
      end
      if (w_load_done) begin
        r_read_data <= mem.mem_resp_rdata;
      end
    end
  end

  assign valid_out      = r_valid;
  assign read_data_out  = r_read_data;
  assign alu_res_out    = r_alu_res;
  assign dest_out       = r_dest;
  assign wb_control_out = r_wb;
endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: driver pushes expected retires and memory
// requests, a memory responder and a MEM/WB monitor pop and compare.
module tb_mem_access_stage;

`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          rdy_dly;
    int          resp_dly;
  } req_t;

  typedef struct {
    logic [63:0] alu;
    logic [63:0] rd;
    logic [4:0]  dest;
    logic [1:0]  wb;
    logic        mis;
    int          cyc;
  } ret_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [63:0] target_in;
  logic        branch_decision_in;
  logic [63:0] alu_res_in;
  logic [63:0] write_data_in;
  logic [4:0]  dest_in;
  logic [2:0]  mem_control_in;
  logic [1:0]  wb_control_in;
  logic        stall_out;
  logic        pc_src_out;
  logic [63:0] target_out;
  logic        valid_out;
  logic [63:0] read_data_out;
  logic [63:0] alu_res_out;
  logic [4:0]  dest_out;
  logic [1:0]  wb_control_out;
  logic        misalign_out;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [63:0] model_rd = 64'd0;
  req_t        q_req[$];
  ret_t        q_ret[$];

  mem_access_stage_if #(.DATA_WIDTH(64)) mem_bus ();

  mem_access_stage #(.DATA_WIDTH(64), .REG_ID_WIDTH(5)) dut (
    .clk                (clk),
    .reset              (reset),
    .valid_in           (valid_in),
    .target_in          (target_in),
    .branch_decision_in (branch_decision_in),
    .alu_res_in         (alu_res_in),
    .write_data_in      (write_data_in),
    .dest_in            (dest_in),
    .mem_control_in     (mem_control_in),
    .wb_control_in      (wb_control_in),
    .stall_out          (stall_out),
    .pc_src_out         (pc_src_out),
    .target_out         (target_out),
    .mem                (mem_bus),
    .valid_out          (valid_out),
    .read_data_out      (read_data_out),
    .alu_res_out        (alu_res_out),
    .dest_out           (dest_out),
    .wb_control_out     (wb_control_out),
    .misalign_out       (misalign_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One instruction: present it, hold while stalled, then queue its expected retire.
  task automatic issue(input logic v, input logic [2:0] mc, input logic [1:0] wb,
                       input logic [63:0] alu, input logic [63:0] wd, input logic [63:0] tgt,
                       input logic dec, input logic [4:0] dst, input logic [63:0] rdata,
                       input int rdy, input int rsp);
    logic memop;
    logic ld;
    logic mis;
    logic s;
    bit   done;
    int   exp_st;
    int   st;
    req_t r;
    ret_t e;
    @(negedge clk);
    valid_in           = v;
    mem_control_in     = mc;
    wb_control_in      = wb;
    alu_res_in         = alu;
    write_data_in      = wd;
    target_in          = tgt;
    branch_decision_in = dec;
    dest_in            = dst;
    memop = v && (mc[1] || mc[0]);
    ld    = mc[1];
    mis   = MIS_EN && memop && (alu[2:0] != 3'd0);
    exp_st = 0;
    if (memop && !mis) begin
      r.we = !ld; r.addr = alu; r.wdata = wd; r.rdata = rdata;
      r.rdy_dly = rdy; r.resp_dly = rsp;
      q_req.push_back(r);
      exp_st = ld ? (1 + rdy + rsp) : (1 + rdy);
    end
    st = 0;
    done = 1'b0;
    for (int c = 0; c < 64; c++) begin
      #4;
      chk("pc_src", 64'(pc_src_out), 64'(v & mc[2] & dec));
      chk("target_out", target_out, tgt);
      s = stall_out;
      @(posedge clk);
      if (!s) begin
        done = 1'b1;
        break;
      end
      st++;
      @(negedge clk);
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL stall_timeout: stall_out still 1 after 64 cycles, expected 0");
    end else begin
      chk("stall_cycles", 64'(st), 64'(exp_st));
      if (v) begin
        #1;
        if (memop && !mis && ld) model_rd = rdata;
        e.alu  = alu;
        e.dest = dst;
        e.wb   = mis ? {1'b0, wb[0]} : wb;
        e.rd   = model_rd;
        e.mis  = mis;
        e.cyc  = cyc;
        q_ret.push_back(e);
      end
    end
  endtask

  // Memory responder: checks each request and answers with the queued timing/data.
  initial begin : mem_model
    req_t r;
    mem_bus.mem_req_ready  = 1'b0;
    mem_bus.mem_resp_valid = 1'b0;
    mem_bus.mem_resp_rdata = 64'd0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && mem_bus.mem_req_valid === 1'b1) begin
        if (q_req.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_request: mem_req_valid=1 addr=0x%0h, expected no request",
                   mem_bus.mem_req_addr);
        end else begin
          r = q_req.pop_front();
          chk("req_we", 64'(mem_bus.mem_req_we), 64'(r.we));
          chk("req_addr", mem_bus.mem_req_addr, r.addr);
          chk("req_wdata", mem_bus.mem_req_wdata, r.wdata);
          for (int i = 0; i < r.rdy_dly; i++) begin
            @(negedge clk);
            chk("req_valid_hold", 64'(mem_bus.mem_req_valid), 64'd1);
            chk("req_we_hold", 64'(mem_bus.mem_req_we), 64'(r.we));
            chk("req_addr_hold", mem_bus.mem_req_addr, r.addr);
          end
          mem_bus.mem_req_ready = 1'b1;
          @(negedge clk);
          mem_bus.mem_req_ready = 1'b0;
          if (!r.we) begin
            for (int i = 1; i < r.resp_dly; i++) @(negedge clk);
            mem_bus.mem_resp_valid = 1'b1;
            mem_bus.mem_resp_rdata = r.rdata;
            @(negedge clk);
            mem_bus.mem_resp_valid = 1'b0;
            mem_bus.mem_resp_rdata = {$urandom, $urandom};
          end
        end
      end
    end
  end

  // MEM/WB monitor: every valid_out pops one expected retire; bubbles must clear wb.
  initial begin : monitor
    ret_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (valid_out === 1'b1) begin
          if (q_ret.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_retire: valid_out=1 alu_res_out=0x%0h, expected bubble",
                     alu_res_out);
          end else begin
            e = q_ret.pop_front();
            chk("retire_cycle", 64'(cyc), 64'(e.cyc));
            chk("alu_res_out", alu_res_out, e.alu);
            chk("dest_out", 64'(dest_out), 64'(e.dest));
            chk("wb_control_out", 64'(wb_control_out), 64'(e.wb));
            chk("read_data_out", read_data_out, e.rd);
            chk("misalign_out", 64'(misalign_out), 64'(e.mis));
          end
        end else begin
          chk("bubble_wb", 64'(wb_control_out), 64'd0);
        end
      end
    end
  end

  task automatic chk_reset_state();
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_read_data", read_data_out, 64'd0);
    chk("rst_alu_res", alu_res_out, 64'd0);
    chk("rst_dest", 64'(dest_out), 64'd0);
    chk("rst_wb", 64'(wb_control_out), 64'd0);
    chk("rst_misalign", 64'(misalign_out), 64'd0);
    chk("rst_req_valid", 64'(mem_bus.mem_req_valid), 64'd0);
    chk("rst_stall", 64'(stall_out), 64'd0);
  endtask

  initial begin : stim
    req_t        r;
    logic [63:0] a;
    reset              = 1'b0;
    valid_in           = 1'b0;
    target_in          = 64'd0;
    branch_decision_in = 1'b0;
    alu_res_in         = 64'd0;
    write_data_in      = 64'd0;
    dest_in            = 5'd0;
    mem_control_in     = 3'd0;
    wb_control_in      = 2'd0;
    repeat (3) @(negedge clk);
    #1 chk_reset_state();
    @(negedge clk);
    reset = 1'b1;

    // Directed cases
    issue(1'b1, 3'b000, 2'b10, 64'h10, 64'h0, 64'h0, 1'b0, 5'd3, 64'h0, 0, 1);
    issue(1'b1, 3'b010, 2'b11, 64'h100, 64'h0, 64'h0, 1'b0, 5'd9, 64'hDEADBEEF, 2, 3);
    issue(1'b1, 3'b001, 2'b00, 64'h208, 64'h55, 64'h0, 1'b0, 5'd4, 64'h0, 0, 1);
    issue(1'b1, 3'b100, 2'b00, 64'h0, 64'h0, 64'h400, 1'b1, 5'd0, 64'h0, 0, 1);
    issue(1'b1, 3'b100, 2'b00, 64'h0, 64'h0, 64'h400, 1'b0, 5'd0, 64'h0, 0, 1);
    issue(1'b0, 3'b010, 2'b11, 64'h40, 64'h0, 64'h8, 1'b1, 5'd1, 64'h0, 0, 1);
    issue(1'b1, 3'b010, 2'b11, 64'h103, 64'h0, 64'h0, 1'b0, 5'd6, 64'h0000CAFE, 1, 1);
    issue(1'b1, 3'b011, 2'b11, 64'h118, 64'h77, 64'h0, 1'b0, 5'd7, 64'h12345678, 0, 1);
    issue(1'b1, 3'b001, 2'b10, 64'h300, 64'h99, 64'h0, 1'b0, 5'd8, 64'h0, 3, 1);
    issue(1'b0, 3'b000, 2'b00, 64'h0, 64'h0, 64'h0, 1'b0, 5'd0, 64'h0, 0, 1);

    // Reset while a load waits for its response; the late response must be ignored
    @(negedge clk);
    valid_in = 1'b1; mem_control_in = 3'b010; wb_control_in = 2'b11;
    alu_res_in = 64'h500; write_data_in = 64'h0; dest_in = 5'd11;
    r.we = 1'b0; r.addr = 64'h500; r.wdata = 64'h0; r.rdata = 64'h1234;
    r.rdy_dly = 0; r.resp_dly = 4;
    q_req.push_back(r);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    reset    = 1'b0;
    valid_in = 1'b0;
    model_rd = 64'd0;
    #1 chk_reset_state();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("post_rst_stall", 64'(stall_out), 64'd0);
      chk("post_rst_req_valid", 64'(mem_bus.mem_req_valid), 64'd0);
      chk("post_rst_valid_out", 64'(valid_out), 64'd0);
    end
    chk("stray_resp_ignored", read_data_out, 64'd0);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[2:0] = 3'd0;
      issue(($urandom_range(0, 9) != 0), 3'($urandom), 2'($urandom), a,
            {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 5'($urandom),
            {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(1, 4));
    end

    @(negedge clk);
    valid_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("retire_queue_empty", 64'(q_ret.size()), 64'd0);
    chk("request_queue_empty", 64'(q_req.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage pipeline; consumes the EX/MEM register outputs.
- Resolves taken branches.
- Issues load/store requests to the data memory over a valid/ready request channel and a valid response channel.
- Stalls upstream while an access is in flight and registers results for writeback.
- Owns the MEM/WB payload registers.

Parameters:
DATA_WIDTH, 64, width of address, ALU result, store data and load data
REG_ID_WIDTH, 5, destination register ID width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
valid_in  in  1  EX/MEM holds a valid instruction
target_in  in  DATA_WIDTH  branch target from EX/MEM
branch_decision_in  in  1  ALU branch condition
alu_res_in  in  DATA_WIDTH  ALU result / memory address
write_data_in  in  DATA_WIDTH  store data
dest_in  in  REG_ID_WIDTH  writeback destination
mem_control_in  in  3  {branch, mem_read, mem_write}
wb_control_in  in  2  {reg_write, mem_to_reg}
stall_out  out  1  hold EX/MEM and earlier stages
pc_src_out  out  1  redirect fetch to target_out
target_out  out  DATA_WIDTH  redirect target (equals target_in)
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1 = store, 0 = load
mem_req_addr  out  DATA_WIDTH  byte address
mem_req_wdata  out  DATA_WIDTH  store data
mem_resp_valid  in  1  load data valid
mem_resp_rdata  in  DATA_WIDTH  load data
valid_out  out  1  MEM/WB holds a valid instruction
read_data_out  out  DATA_WIDTH  registered load data
alu_res_out  out  DATA_WIDTH  registered ALU result
dest_out  out  REG_ID_WIDTH  registered destination
wb_control_out  out  2  registered {reg_write, mem_to_reg}
misalign_out  out  1  registered misaligned-access flag

Behaviour:
- Reset (reset=0, async): state IDLE. All registered outputs are 0; mem_req_valid=0. Any in-flight access is abandoned and a later mem_resp_valid is ignored.
- Combinational: pc_src_out = valid_in & mem_control_in[2] & branch_decision_in; target_out = target_in.
- memop = valid_in & (mem_read | mem_write). Both bits set means the access is a load.
- Upstream holds all *_in stable while stall_out=1. mem_req_addr/wdata are driven straight from alu_res_in/write_data_in.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - stall_out = memop.
  - If memop, go to REQ. Otherwise, if valid_in, retire a non-memory op.
- REQ:
  - mem_req_valid=1 and mem_req_we=mem_write&~mem_read. Both outputs stay stable until mem_req_ready=1.
  - Ready and store: retire; stall_out=0; go to IDLE.
  - Ready and load: stall_out=1; go to WAIT.
  - Not ready: stall_out=1; stay in REQ.
- WAIT:
  - stall_out = ~mem_resp_valid.
  - On mem_resp_valid: capture rdata, retire, go to IDLE.
  - A response in the same cycle as acceptance is not legal; it arrives at least one cycle later.
- mem_resp_valid is ignored in IDLE and REQ.
- Retire means that at the next edge:
  - valid_out=1
  - alu_res_out, dest_out, wb_control_out take the current inputs
  - read_data_out takes rdata on a load, otherwise holds its value
- Any cycle without a retire writes a bubble at the next edge: valid_out=0 and wb_control_out=0. Other payload fields hold.
- Latency:
  - non-memory op: 1 cycle
  - store: 2 cycles minimum
  - load: 3 cycles minimum
- Back-to-back: a new memop is seen in IDLE on the cycle after a retire, with no lost cycles beyond the stated latency.

Optional Feature:
MEM_MISALIGN_CHECK_EN
- Defined:
  - A memop with alu_res_in[2:0]!=0 issues no request and retires from IDLE in 1 cycle with stall_out=0.
  - misalign_out=1 and wb_control_out[1] (reg_write) is forced to 0.
- Undefined: no check is made; misalign_out is tied to 0.

Decomposition:
- Package mem_stage_pkg holds:
  - state enum mem_state_e {IDLE, REQ, WAIT}
  - bit-index constants MEMCTL_BRANCH=2, MEMCTL_READ=1, MEMCTL_WRITE=0, WBCTL_REG_WRITE=1, WBCTL_MEM_TO_REG=0
- One sub-module, mem_req_fsm: state register, next-state logic, stall_out, mem_req_valid/we and a retire strobe. The top-level module holds the MEM/WB payload registers.

Test Plan:
- Non-memory op (valid_in=1, mem_control=000, alu_res=0x10, dest=3, wb=10) -> no request; next cycle valid_out=1, alu_res_out=0x10, dest_out=3, stall_out never high.
- Load at 0x100, ready held low 2 cycles, response 3 cycles after accept with rdata=0xDEADBEEF -> mem_req_valid/addr stable throughout; stall_out high until response; read_data_out=0xDEADBEEF, wb_control_out=11.
- Store 0x55 at 0x208 with ready=1 immediately -> mem_req_we=1, wdata=0x55; retire 2 cycles after valid_in; no read_data_out update.
- Branch with decision=1, target 0x400 -> pc_src_out=1 and target_out=0x400 in the same cycle; decision=0 -> pc_src_out=0.
- Reset asserted in WAIT, then a stray mem_resp_valid -> state IDLE, valid_out=0, response ignored.
- With MEM_MISALIGN_CHECK_EN, load at 0x103 -> no mem_req_valid; next cycle misalign_out=1, wb_control_out[1]=0.
